// File: rtl/hs_branch_align_pkg.sv
// Shared definitions for the Newton datapath handshake stages.
// It holds the default operand width, the default branch buffer depth,
// and the operand word type used between stages.
package newton_hs_pkg;

    localparam int NEWTON_W     = 2;
    localparam int NEWTON_DEPTH = 8;

    typedef logic [NEWTON_W-1:0] operand_t;

endpackage : newton_hs_pkg

// File: rtl/hs_branch_align_if.sv
// Handshake bundle for the branch/main operand join.
// - master: the side that offers operands and accepts the paired result.
// - slave: the join block itself.
interface hs_branch_align_if
    import newton_hs_pkg::*;
#(
    parameter int W     = NEWTON_W,
    parameter int DEPTH = NEWTON_DEPTH
);

    localparam int AW = $clog2(DEPTH);

    // Forked branch operand stream (buffered side)
    logic [W-1:0] a_data;
    logic         a_vd;
    logic         a_rd;

    // Main operand stream (unbuffered side)
    logic [W-1:0] b_data;
    logic         b_vd;
    logic         b_rd;

    // Paired output towards the two-operand consumer
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    logic         out_vd;
    logic         out_rd;

    // Status
    logic [AW:0]  level;
    logic         fork_stall_err;

    modport master (
        output a_data, a_vd, b_data, b_vd, out_rd,
        input  a_rd, b_rd, out_a, out_b, out_vd, level, fork_stall_err
    );

    modport slave (
        input  a_data, a_vd, b_data, b_vd, out_rd,
        output a_rd, b_rd, out_a, out_b, out_vd, level, fork_stall_err
    );

endinterface : hs_branch_align_if

// File: rtl/hs_branch_align_fifo_fwft.sv
// First-word-fall-through FIFO that holds the forked branch operand.
// Full and empty come from the occupancy count, not from comparing pointers,
// so the pointers are free to wrap naturally at DEPTH (a power of two).
// The head word is read combinationally from the memory. A pushed word
// therefore becomes visible on the edge after its push, with no bypass.
module hs_fifo_fwft #(
    parameter int W     = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             pushData_i,
    input  logic                     pop_i,
    output logic [W-1:0]             headData_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   level_q, level_d;
    logic          doPush;
    logic          doPop;

    // Requests are qualified internally so a push into a full buffer or a
    // pop from an empty one can never corrupt the pointers or the count.
    assign full_o     = (level_q == LVL_FULL);
    assign empty_o    = (level_q == '0);
    assign doPush     = push_i && !full_o;
    assign doPop      = pop_i && !empty_o;
    assign headData_o = mem_q[rdPtr_q];
    assign level_o    = level_q;

    // Next pointer and occupancy values. A simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
        end
        case ({doPush, doPop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers. Reset discards every buffered word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

    // Storage array. It has no reset because stale contents are never presented while empty.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

endmodule : hs_fifo_fwft

// File: rtl/hs_branch_align.sv
// Join of the buffered branch operand (the stage-two difference) with the
// unbuffered main operand (the stage-two quotient) for subtractor four.
// A pair is offered only when the branch FIFO holds a word and the main
// stream is valid. Firing the pair pops the FIFO and consumes the main
// word in the same cycle. out_vd depends only on registered occupancy and
// on b_vd, so it has no combinational path from a_vd.
module hs_branch_align
    import newton_hs_pkg::*;
#(
    parameter int W     = NEWTON_W,
    parameter int DEPTH = NEWTON_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    hs_branch_align_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] headData;
    logic [AW:0]  fifoLevel;
    logic         fifoEmpty;
    logic         fifoFull;
    logic         aFire;
    logic         outFire;
    logic         stallErr_q;
    logic         stallErr_d;

    // The branch side is accepted whenever the buffer has room. Its ready
    // comes from registered occupancy only, so a full buffer never lets a
    // word pass through on the strength of a same-cycle pop.
    assign aFire   = bus.a_vd && !fifoFull;
    assign outFire = bus.out_vd && bus.out_rd;

    hs_fifo_fwft #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (aFire),
        .pushData_i (bus.a_data),
        .pop_i      (outFire),
        .headData_o (headData),
        .empty_o    (fifoEmpty),
        .full_o     (fifoFull),
        .level_o    (fifoLevel)
    );

    // Main data is held upstream until a branch word is waiting, so the
    // main producer never sees ready while there is nothing to pair with.
    assign bus.a_rd   = !fifoFull;
    assign bus.out_vd = !fifoEmpty && bus.b_vd;
    assign bus.b_rd   = bus.out_rd && !fifoEmpty;
    assign bus.out_a  = headData;
    assign bus.out_b  = bus.b_data;
    assign bus.level  = fifoLevel;

    // The flag latches any cycle where the fork offered a branch word that
    // could not be taken. That means the buffer depth is too small.
    assign stallErr_d           = stallErr_q || (bus.a_vd && fifoFull);
    assign bus.fork_stall_err   = stallErr_q;

    // Sticky stall flag. Only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallErr_q <= 1'b0;
        end else begin
            stallErr_q <= stallErr_d;
        end
    end

endmodule : hs_branch_align

// File: tb/tb_hs_branch_align.sv
// Bench for the branch/main operand join.
// A queue holds the branch words expected at the FIFO head. An occupancy
// count and a sticky error bit track the state the DUT should be in.
module tb_hs_branch_align;

    import newton_hs_pkg::*;

    localparam int W     = 2;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hs_branch_align_if #(.W(W), .DEPTH(DEPTH)) bus ();

    hs_branch_align #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int           compared   = 0;
    int           mismatched = 0;
    operand_t     expQ[$];
    int           lvlModel   = 0;
    bit           errModel   = 1'b0;
    operand_t     fillPat[8] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};

    // Count one comparison and report it if the observed value differs from the expected one.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of stimulus and check the combinational outputs against the model.
    // Then advance the model and check the registered state after the edge.
    task automatic applyStimulus(input bit av, input operand_t ad, input bit bv,
                                 input operand_t bd, input bit ord);
        bit aRdM;
        bit nonEmpty;
        bit aFireM;
        bit outFireM;
        bus.a_vd   = av;
        bus.a_data = ad;
        bus.b_vd   = bv;
        bus.b_data = bd;
        bus.out_rd = ord;
        #1;
        aRdM     = (lvlModel != DEPTH);
        nonEmpty = (lvlModel != 0);
        checkOutput("a_rd", 32'(bus.a_rd), 32'(aRdM));
        checkOutput("out_vd", 32'(bus.out_vd), 32'(nonEmpty && bv));
        checkOutput("b_rd", 32'(bus.b_rd), 32'(ord && nonEmpty));
        if (bv) checkOutput("out_b", 32'(bus.out_b), 32'(bd));
        if (nonEmpty) checkOutput("out_a", 32'(bus.out_a), 32'(expQ[0]));
        aFireM   = av && aRdM;
        outFireM = bv && ord && nonEmpty;
        if (outFireM) void'(expQ.pop_front());
        if (aFireM) expQ.push_back(ad);
        lvlModel = lvlModel + int'(aFireM) - int'(outFireM);
        if (av && !aRdM) errModel = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("level", 32'(bus.level), 32'(lvlModel));
        checkOutput("stall_err", 32'(bus.fork_stall_err), 32'(errModel));
    endtask

    // Clear the model to match a DUT reset.
    task automatic resetModel();
        expQ.delete();
        lvlModel = 0;
        errModel = 1'b0;
    endtask

    // Watchdog so the run always ends even if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.a_vd   = 1'b0;
        bus.a_data = '0;
        bus.b_vd   = 1'b1;
        bus.b_data = '0;
        bus.out_rd = 1'b1;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
        #1;
        $display("[TB] reset then idle");
        checkOutput("idle_a_rd", 32'(bus.a_rd), 32'd1);
        checkOutput("idle_b_rd", 32'(bus.b_rd), 32'd0);
        checkOutput("idle_out_vd", 32'(bus.out_vd), 32'd0);
        checkOutput("idle_level", 32'(bus.level), 32'd0);
        checkOutput("idle_err", 32'(bus.fork_stall_err), 32'd0);

        $display("[TB] latency");
        applyStimulus(1'b1, 2'b10, 1'b1, 2'b01, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b1, 2'b11, 1'b1);
        checkOutput("lat_level", 32'(bus.level), 32'd0);

        $display("[TB] ordering and fill");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, fillPat[i], 1'b0, 2'b00, 1'b0);
        checkOutput("fill_level", 32'(bus.level), 32'd8);
        checkOutput("fill_a_rd", 32'(bus.a_rd), 32'd0);
        applyStimulus(1'b1, 2'b11, 1'b0, 2'b00, 1'b0);
        checkOutput("stall_set", 32'(bus.fork_stall_err), 32'd1);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        checkOutput("stall_sticky", 32'(bus.fork_stall_err), 32'd1);

        $display("[TB] drain");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 2'b00, 1'b1, operand_t'($urandom), 1'b1);
        checkOutput("drain_level", 32'(bus.level), 32'd0);
        applyStimulus(1'b0, 2'b00, 1'b1, 2'b10, 1'b1);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, 2'b11, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 1'b1, 2'b10, 1'b0);
        checkOutput("bp_level", 32'(bus.level), 32'd2);
        applyStimulus(1'b0, 2'b00, 1'b1, 2'b10, 1'b1);
        checkOutput("bp_single_pop", 32'(bus.level), 32'd1);
        applyStimulus(1'b0, 2'b00, 1'b1, 2'b00, 1'b1);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, operand_t'(i + 1), 1'b0, 2'b00, 1'b0);
        bus.a_vd   = 1'b0;
        bus.b_vd   = 1'b1;
        bus.out_rd = 1'b0;
        #1;
        checkOutput("pre_rst_out_vd", 32'(bus.out_vd), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_level", 32'(bus.level), 32'd0);
        checkOutput("async_rst_out_vd", 32'(bus.out_vd), 32'd0);
        checkOutput("async_rst_err", 32'(bus.fork_stall_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();

        $display("[TB] concurrent with wrap");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, operand_t'($urandom), 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, operand_t'($urandom), 1'b1, operand_t'($urandom), 1'b1);
            checkOutput("wrap_level", 32'(bus.level), 32'd3);
        end
        checkOutput("wrap_err", 32'(bus.fork_stall_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_hs_branch_align

// File: doc/hs_branch_align.md
Name: hs_branch_align

Overview:
- Handshake join for the Newton datapath.
- Buffers a forked branch operand (the stage-two difference tapped off its valid/ready stream) in a first-word-fall-through FIFO.
- Presents the head entry paired with a second, unbuffered stream (the stage-two quotient) to a downstream two-operand consumer (subtractor four) only when both are valid.
- It is the consuming/reader end of the valid/ready protocol. It replaces ad hoc shift-register alignment of forked operands with a back-pressured, depth-bounded buffer.

Parameters:
- W, 2, data width of both operand streams.
- DEPTH, 8, branch FIFO entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- a_data  in  W  branch operand (forked stream)
- a_vd  in  1  branch valid
- a_rd  out  1  branch ready (FIFO not full)
- b_data  in  W  main operand
- b_vd  in  1  main valid
- b_rd  out  1  main ready
- out_a  out  W  aligned branch operand (FIFO head)
- out_b  out  W  aligned main operand
- out_vd  out  1  paired output valid
- out_rd  in  1  downstream ready
- level  out  AW+1  current FIFO occupancy
- fork_stall_err  out  1  sticky: branch offered while FIFO full

Behaviour:
- Reset (async assert, sync-safe deassert on clk): wr_ptr=0, rd_ptr=0, level=0, fork_stall_err=0. Consequently out_vd=0, a_rd=1, b_rd=0. Memory contents are don't-care, and out_a is don't-care while level=0.
- Push: a_fire = a_vd && a_rd. On a rising clk with a_fire, write a_data at wr_ptr and increment wr_ptr (mod DEPTH).
- a_rd = (level != DEPTH), combinational from registered level only. It never depends on a pop in the same cycle, so there is no full-state pass-through.
- Head: out_a = mem[rd_ptr], combinational. A pushed word is visible at out_a one cycle after its push edge. There is no same-cycle bypass, so minimum branch latency is 1 cycle.
- Join:
  - out_vd = (level != 0) && b_vd
  - out_b = b_data, passthrough
  - b_rd = out_rd && (level != 0)
  - out_fire = out_vd && out_rd, which equals b_fire
- Pop: on out_fire, increment rd_ptr (mod DEPTH). The main stream is consumed in the same cycle.
- No combinational path from a_vd to out_vd.
- Simultaneous push and pop: level unchanged, both pointers advance. This is legal at any level 1..DEPTH-1, and at DEPTH only the pop occurs (a_rd=0).
- Level update: level += a_fire - out_fire. It saturates only by construction and never exceeds DEPTH or goes below 0.
- Pointer wrap: natural AW-bit wrap. Full/empty are decided by level, not by pointer compare.
- fork_stall_err: set on any clk edge with a_vd && !a_rd. Cleared only by rst. It flags that the upstream fork had to stall, i.e. DEPTH is undersized.
- Stability: once out_vd=1, it holds with out_a stable until out_fire, because the head only changes on pop. out_b stability is the main producer's obligation.
- Reset mid-operation: all buffered entries are discarded and out_vd drops immediately (async). In-flight handshakes that cycle are not completed.
- Main stream arriving first: b_vd=1 with level=0 gives b_rd=0, so main is held upstream until a branch word lands.

Decomposition:
- Shared package newton_hs_pkg: W default, DEPTH default, and a typedef for the operand word shared by the Newton stages.
- One natural sub-module, hs_fifo_fwft. It holds the memory, pointers, level, a_rd and head read, and exposes push, pop, empty, full and level.
- hs_branch_align wraps it with the join logic and the sticky error.

Test Plan:
- Reset then idle: after rst release, expect a_rd=1, b_rd=0, out_vd=0, level=0, fork_stall_err=0. Assert rst mid-stream with level=3 and expect level=0 and out_vd=0 without waiting for a clk edge.
- Latency: push a_data=2'b10 with b_vd=1 and out_rd=1 held. Expect out_vd=1 with out_a=2'b10 exactly one cycle later, then pop, then level=0.
- Ordering and fill: push 8 words 01,10,11,00,01,10,11,00 with b_vd=0. Expect level=8 and a_rd=0. Then drive a_vd=1 for one cycle and expect fork_stall_err=1, sticky.
- Drain: from full, b_vd=1 and out_rd=1 for 8 cycles. Expect out_a to match the push order, one pop per cycle, level to reach 0, and out_vd to fall in the cycle after the last pop.
- Back-pressure: level=2, b_vd=1, out_rd=0 for 3 cycles. Expect out_vd=1, out_a stable, b_rd=0, level=2. Then out_rd=1 and expect a single pop.
- Concurrent with wrap: run continuous a_vd, b_vd and out_rd for 20 cycles after a 3-word prefill. Expect level constant at 3, FIFO-order outputs across pointer wrap, and fork_stall_err=0.
